sram_responder: RTL and testbench

//  Device-side (responder) model of the 256Kx16 async SRAM that the pipeline's SRAM controller drives.

---
 rtl/sram_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_sram_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Purpose : device-side stand-in for a 256Kx16 async SRAM, answering the controller's SRAM_* pins.
// Latency : read data on DQ RD_WAIT edges after the request is sampled; write commits WR_WAIT edges after sampling.
// Backpress: none. The controller paces itself by holding the pins; busy reports a transaction in flight.
//
// Ports:
//   clk, rst        - clock (rising edge) and asynchronous active-low reset
//   SRAM_ADDR       - word address; only the low log2(DEPTH) bits select a word
//   SRAM_DQ         - bidirectional data; driven only in RD_DRIVE while CE_N=0, OE_N=0, WE_N=1
//   SRAM_UB_N/LB_N  - active-low byte lane enables (UB=[15:8], LB=[7:0])
//   SRAM_WE_N/CE_N/OE_N - active-low write, chip and output enables
//   busy            - high whenever the FSM is outside IDLE
//   monitor_addr    - debug word index
//   monitor_data    - combinational readout of the word at monitor_addr

module sram_responder #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic              busy,
    input  logic [3:0]        monitor_addr,
    output logic [DATA_W-1:0] monitor_data
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int LANE_W   = DATA_W / 2;
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_DRIVE,
        ST_WR_WAIT,
        ST_WR_DONE
    } state_t;

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  lat_idx, lat_idx_nxt;
    logic              lat_ub_n, lat_ub_n_nxt;
    logic              lat_lb_n, lat_lb_n_nxt;
    logic              wr_commit;

    logic [IDX_W-1:0]  addr_idx;
    logic              lane_any;
    logic              wr_req;
    logic              rd_req;
    logic              rd_exit;
    logic              wr_abort;
    logic              addr_chg;
    logic              dq_oe;
    logic [DATA_W-1:0] rd_dat;

    // High address bits are aliases of the low DEPTH words and are ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^SRAM_ADDR[ADDR_W-1:IDX_W];

    assign addr_idx = SRAM_ADDR[IDX_W-1:0];
    assign lane_any = !SRAM_UB_N || !SRAM_LB_N;

    // Write decodes regardless of OE_N so a WE_N/OE_N overlap never turns into a read.
    assign wr_req   = !SRAM_CE_N && !SRAM_WE_N && lane_any;
    assign rd_req   = !SRAM_CE_N && !SRAM_OE_N &&  SRAM_WE_N && lane_any;
    assign rd_exit  =  SRAM_CE_N ||  SRAM_OE_N || !SRAM_WE_N;
    assign wr_abort =  SRAM_CE_N ||  SRAM_WE_N;
    assign addr_chg = (addr_idx != lat_idx);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lat_idx  <= '0;
            lat_ub_n <= 1'b0;
            lat_lb_n <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lat_idx  <= lat_idx_nxt;
            lat_ub_n <= lat_ub_n_nxt;
            lat_lb_n <= lat_lb_n_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        lat_idx_nxt  = lat_idx;
        lat_ub_n_nxt = lat_ub_n;
        lat_lb_n_nxt = lat_lb_n;
        wr_commit    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    state_nxt    = ST_WR_WAIT;
                    cnt_nxt      = WR_LOAD;
                    lat_idx_nxt  = addr_idx;
                    lat_ub_n_nxt = SRAM_UB_N;
                    lat_lb_n_nxt = SRAM_LB_N;
                end else if (rd_req) begin
                    state_nxt    = ST_RD_WAIT;
                    cnt_nxt      = RD_LOAD;
                    lat_idx_nxt  = addr_idx;
                    lat_ub_n_nxt = SRAM_UB_N;
                    lat_lb_n_nxt = SRAM_LB_N;
                end
            end

            ST_RD_WAIT: begin
                if (rd_exit) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (addr_chg) begin
                    // New address restarts the full access time.
                    cnt_nxt      = RD_LOAD;
                    lat_idx_nxt  = addr_idx;
                    lat_ub_n_nxt = SRAM_UB_N;
                    lat_lb_n_nxt = SRAM_LB_N;
                end else if (cnt == '0) begin
                    // Re-sample lanes as the bus turns around, so late lane changes are honoured.
                    state_nxt    = ST_RD_DRIVE;
                    lat_idx_nxt  = addr_idx;
                    lat_ub_n_nxt = SRAM_UB_N;
                    lat_lb_n_nxt = SRAM_LB_N;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            ST_RD_DRIVE: begin
                if (rd_exit) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (addr_chg) begin
                    state_nxt    = ST_RD_WAIT;
                    cnt_nxt      = RD_LOAD;
                    lat_idx_nxt  = addr_idx;
                    lat_ub_n_nxt = SRAM_UB_N;
                    lat_lb_n_nxt = SRAM_LB_N;
                end
            end

            ST_WR_WAIT: begin
                if (wr_abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    wr_commit = 1'b1;
                    state_nxt = ST_WR_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            ST_WR_DONE: begin
                // Hold here until the strobe is released: one commit per WE_N pulse.
                if (wr_abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Array write: only enabled lanes are updated. The FSM is forced to
    // IDLE by reset, so a reset before the commit edge leaves the array alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            if (!lat_lb_n) begin
                mem[lat_idx][LANE_W-1:0] <= SRAM_DQ[LANE_W-1:0];
            end
            if (!lat_ub_n) begin
                mem[lat_idx][DATA_W-1:LANE_W] <= SRAM_DQ[DATA_W-1:LANE_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read drive: releases combinationally on CE_N/OE_N rising (and on
    // WE_N falling) so the controller never fights this block.
    // ------------------------------------------------------------------
    always_comb begin
        rd_dat = '0;
        if (!lat_ub_n) begin
            rd_dat[DATA_W-1:LANE_W] = mem[lat_idx][DATA_W-1:LANE_W];
        end
        if (!lat_lb_n) begin
            rd_dat[LANE_W-1:0] = mem[lat_idx][LANE_W-1:0];
        end
    end

    assign dq_oe   = (state == ST_RD_DRIVE) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign SRAM_DQ = dq_oe ? rd_dat : {DATA_W{1'bz}};

    assign busy         = (state != ST_IDLE);
    assign monitor_data = mem[IDX_W'(monitor_addr)];

endmodule

// File: tb/tb_sram_responder.sv
// Purpose : directed checks of the SRAM responder: reset, write/read latency, byte lanes, wrap, abort, contention.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpress: none; the DUT has no flow control.

module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    logic        busy;
    logic [3:0]  mon_addr;
    logic [15:0] mon_dat;

    // Pull-up so an undriven bus reads as all ones; test data never uses 16'hFFFF.
    tri1  [15:0] sram_dq;
    logic        tb_dq_en;
    logic [15:0] tb_dq_val;
    assign sram_dq = tb_dq_en ? tb_dq_val : 16'hzzzz;

    localparam logic [15:0] HIZ = 16'hFFFF;

    int n_total = 0;
    int n_bad   = 0;

    sram_responder #(
        .ADDR_W (18),
        .DATA_W (16),
        .DEPTH  (1024),
        .RD_WAIT(2),
        .WR_WAIT(2)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .SRAM_ADDR   (addr),
        .SRAM_DQ     (sram_dq),
        .SRAM_UB_N   (ub_n),
        .SRAM_LB_N   (lb_n),
        .SRAM_WE_N   (we_n),
        .SRAM_CE_N   (ce_n),
        .SRAM_OE_N   (oe_n),
        .busy        (busy),
        .monitor_addr(mon_addr),
        .monitor_data(mon_dat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic ce, input logic oe, input logic we,
                           input logic ub, input logic lb, input logic [17:0] a);
        ce_n = ce; oe_n = oe; we_n = we; ub_n = ub; lb_n = lb; addr = a;
    endtask

    task automatic bus_idle();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        tb_dq_en = 1'b0;
    endtask

    // Full write cycle: sample edge, one wait edge, commit edge, release.
    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
        set_bus(1'b0, 1'b1, 1'b0, ub, lb, a);
        tb_dq_val = d;
        tb_dq_en  = 1'b1;
        tick(); tick(); tick();
        bus_idle();
        tick();
    endtask

    // Read request held for sample edge plus RD_WAIT edges: DQ valid afterwards.
    task automatic start_read(input logic [17:0] a, input logic ub, input logic lb);
        set_bus(1'b0, 1'b0, 1'b1, ub, lb, a);
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_total++;
        if (sram_dq !== HIZ) begin
            n_bad++; $display("FAIL reset_dq: got %h want %h (undriven)", sram_dq, HIZ);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        do_write(18'h00005, 16'hBEEF, 1'b0, 1'b0);
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00005);
        tick();
        n_total++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL wr_rd_busy: got %b want 1", busy);
        end
        n_total++;
        if (sram_dq !== HIZ) begin
            n_bad++; $display("FAIL wr_rd_dq_edge0: got %h want %h", sram_dq, HIZ);
        end
        tick();
        n_total++;
        if (sram_dq !== HIZ) begin
            n_bad++; $display("FAIL wr_rd_dq_edge1: got %h want %h", sram_dq, HIZ);
        end
        tick();
        n_total++;
        if (sram_dq !== 16'hBEEF) begin
            n_bad++; $display("FAIL wr_rd_dq_edge2: got %h want BEEF", sram_dq);
        end
        oe_n = 1'b1;
        #1;
        n_total++;
        if (sram_dq !== HIZ) begin
            n_bad++; $display("FAIL wr_rd_oe_release: got %h want %h", sram_dq, HIZ);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_byte_lanes();
        do_write(18'h00005, 16'h1234, 1'b1, 1'b0);
        start_read(18'h00005, 1'b0, 1'b0);
        n_total++;
        if (sram_dq !== 16'hBE34) begin
            n_bad++; $display("FAIL lanes_both: got %h want BE34", sram_dq);
        end
        bus_idle();
        tick();
        start_read(18'h00005, 1'b0, 1'b1);
        n_total++;
        if (sram_dq !== 16'hBE00) begin
            n_bad++; $display("FAIL lanes_ub_only: got %h want BE00", sram_dq);
        end
        bus_idle();
        tick();
        mon_addr = 4'd5;
        #1;
        n_total++;
        if (mon_dat !== 16'hBE34) begin
            n_bad++; $display("FAIL lanes_monitor: got %h want BE34", mon_dat);
        end
    endtask

    task automatic test_wrap();
        do_write(18'h00407, 16'h00AA, 1'b0, 1'b0);
        start_read(18'h00007, 1'b0, 1'b0);
        n_total++;
        if (sram_dq !== 16'h00AA) begin
            n_bad++; $display("FAIL wrap_read: got %h want 00AA", sram_dq);
        end
        bus_idle();
        tick();
        mon_addr = 4'd7;
        #1;
        n_total++;
        if (mon_dat !== 16'h00AA) begin
            n_bad++; $display("FAIL wrap_monitor: got %h want 00AA", mon_dat);
        end
    endtask

    task automatic test_addr_change();
        start_read(18'h00005, 1'b0, 1'b0);
        addr = 18'h00007;
        tick();
        n_total++;
        if (sram_dq !== HIZ) begin
            n_bad++; $display("FAIL addr_chg_release: got %h want %h", sram_dq, HIZ);
        end
        tick(); tick();
        n_total++;
        if (sram_dq !== 16'h00AA) begin
            n_bad++; $display("FAIL addr_chg_data: got %h want 00AA", sram_dq);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_abort();
        do_write(18'h00009, 16'h1111, 1'b0, 1'b0);
        set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00009);
        tb_dq_val = 16'hDEAD;
        tb_dq_en  = 1'b1;
        tick();
        we_n = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_busy: got %b want 0", busy);
        end
        bus_idle();
        tick(); tick();
        mon_addr = 4'd9;
        #1;
        n_total++;
        if (mon_dat !== 16'h1111) begin
            n_bad++; $display("FAIL abort_word: got %h want 1111", mon_dat);
        end
    endtask

    task automatic test_contention();
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0000A);
        tb_dq_en = 1'b0;
        tick();
        n_total++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL cont_busy: got %b want 1", busy);
        end
        n_total++;
        if (sram_dq !== HIZ) begin
            n_bad++; $display("FAIL cont_dq_wait: got %h want %h", sram_dq, HIZ);
        end
        tb_dq_val = 16'h5A5A;
        tb_dq_en  = 1'b1;
        tick(); tick();
        tb_dq_en = 1'b0;
        #1;
        n_total++;
        if (sram_dq !== HIZ) begin
            n_bad++; $display("FAIL cont_dq_done: got %h want %h", sram_dq, HIZ);
        end
        bus_idle();
        tick();
        mon_addr = 4'd10;
        #1;
        n_total++;
        if (mon_dat !== 16'h5A5A) begin
            n_bad++; $display("FAIL cont_word: got %h want 5A5A", mon_dat);
        end
    endtask

    task automatic test_reset_mid_read();
        start_read(18'h00005, 1'b0, 1'b0);
        n_total++;
        if (sram_dq !== 16'hBE34) begin
            n_bad++; $display("FAIL rst_rd_before: got %h want BE34", sram_dq);
        end
        rst_n = 1'b0;
        #1;
        n_total++;
        if (sram_dq !== HIZ) begin
            n_bad++; $display("FAIL rst_rd_dq: got %h want %h", sram_dq, HIZ);
        end
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_rd_busy: got %b want 0", busy);
        end
        bus_idle();
        #2;
        rst_n = 1'b1;
        tick();
        start_read(18'h00005, 1'b0, 1'b0);
        n_total++;
        if (sram_dq !== 16'hBE34) begin
            n_bad++; $display("FAIL rst_rd_after: got %h want BE34", sram_dq);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_reset_mid_write();
        do_write(18'h0000C, 16'h3C3C, 1'b0, 1'b0);
        set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0000C);
        tb_dq_val = 16'h7777;
        tb_dq_en  = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        bus_idle();
        #2;
        rst_n = 1'b1;
        tick();
        mon_addr = 4'd12;
        #1;
        n_total++;
        if (mon_dat !== 16'h3C3C) begin
            n_bad++; $display("FAIL rst_wr_word: got %h want 3C3C", mon_dat);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        addr      = '0;
        tb_dq_val = '0;
        mon_addr  = '0;
        bus_idle();
        #12;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wrap();
        test_addr_change();
        test_abort();
        test_contention();
        test_reset_mid_read();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
